shift_ext_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle stage-4 shifter/extender datapath.
- Accepts an operand, a shift-mode code and an IMM_W-bit immediate, which is also the shift amount.
- Returns the shifted result, a zero-flag, and zero/sign-extended copies of the immediate after STAGES cycles.
- Uses a valid/ready handshake so the multi-cycle control unit can stall it.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_level.sv | 27 ++
 rtl/shift_ext_pipe.sv | 154 +++++++++++++++
 tb/tb_shift_ext_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shifter/extender: mode codes and the
// helpers that spread the barrel levels across register stages.
package shift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_SLL  = 3'd0;
   localparam mode_t MODE_SRL  = 3'd1;
   localparam mode_t MODE_SRA  = 3'd2;
   localparam mode_t MODE_ROL  = 3'd3;
   localparam mode_t MODE_ROR  = 3'd4;
   localparam mode_t MODE_PASS = 3'd5;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // Levels owned by stage s; earlier stages absorb the remainder.
   function automatic int lvl_count(input int lv, input int st, input int s);
      return lv / st + ((s < lv % st) ? 1 : 0);
   endfunction

   function automatic int lvl_first(input int lv, input int st, input int s);
      return s * (lv / st) + ((s < lv % st) ? s : lv % st);
   endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel level: optionally moves the word by DIST bits,
// left or right, either rotating or filling with i_fill.
module shift_level #(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  logic             i_left,
   input  logic             i_rot,
   input  logic             i_fill,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] w_fill;
   logic [WIDTH-1:0] w_left;
   logic [WIDTH-1:0] w_right;

   assign w_fill  = {WIDTH{i_fill}};
   // The bits shifted out wrap around for rotates, otherwise fill bits come in.
   assign w_left  = (i_data << DIST) |
                    (i_rot ? (i_data >> (WIDTH - DIST)) : (w_fill >> (WIDTH - DIST)));
   assign w_right = (i_data >> DIST) |
                    (i_rot ? (i_data << (WIDTH - DIST)) : (w_fill << (WIDTH - DIST)));
   assign o_data  = !i_en ? i_data : (i_left ? w_left : w_right);

endmodule

// File: rtl/shift_ext_pipe.sv
// Pipelined shifter / immediate extender with a valid/ready handshake.
// The whole pipe advances together whenever the output slot is free or drained.
module shift_ext_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int IMM_W  = 12,
   parameter int STAGES = 2
) (
   input  logic             CLK,
   input  logic             CtrlRstN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_zext,
   output logic [WIDTH-1:0] out_sext
);

   localparam int LV = clog2(WIDTH);

   logic             w_adv;
   logic [WIDTH-1:0] w_imm_ext;
   logic [LV-1:0]    w_amt0;
   logic             w_sat0;
   logic             w_fill0;

   // Index s is what feeds stage s: the decoded input for s=0, else register s-1.
   logic [STAGES-1:0]            w_in_vld;
   logic [STAGES-1:0]            w_in_sat;
   logic [STAGES-1:0]            w_in_fill;
   logic [STAGES-1:0][2:0]       w_in_mode;
   logic [STAGES-1:0][LV-1:0]    w_in_amt;
   logic [STAGES-1:0][WIDTH-1:0] w_in_data;
   logic [STAGES-1:0][WIDTH-1:0] w_in_zext;
   logic [STAGES-1:0][WIDTH-1:0] w_in_sext;
   logic [STAGES-1:0][WIDTH-1:0] w_nxt_data;

   logic [STAGES-1:0]            r_vld;
   logic [STAGES-1:0][WIDTH-1:0] r_data;
   logic [STAGES-1:0][WIDTH-1:0] r_zext;
   logic [STAGES-1:0][WIDTH-1:0] r_sext;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   assign w_imm_ext = WIDTH'(in_imm);
   assign w_amt0    = (in_mode >= MODE_PASS) ? '0 : w_imm_ext[LV-1:0];
   assign w_sat0    = (in_mode == MODE_SLL || in_mode == MODE_SRL || in_mode == MODE_SRA) &&
                      (|(w_imm_ext >> LV));
   assign w_fill0   = (in_mode == MODE_SRA) && in_data[WIDTH-1];

   assign w_in_vld[0]  = in_valid;
   assign w_in_data[0] = in_data;
   assign w_in_zext[0] = w_imm_ext;
   assign w_in_sext[0] = WIDTH'($signed(in_imm));
   assign w_in_mode[0] = in_mode;
   assign w_in_amt[0]  = w_amt0;
   assign w_in_sat[0]  = w_sat0;
   assign w_in_fill[0] = w_fill0;

   // Shift controls only need to reach the stages that still have levels to apply.
   if (STAGES > 1) begin : g_sb
      logic [STAGES-2:0]         r_sat;
      logic [STAGES-2:0]         r_fill;
      logic [STAGES-2:0][2:0]    r_mode;
      logic [STAGES-2:0][LV-1:0] r_amt;

      always_ff @(posedge CLK) begin
         if (!CtrlRstN) begin
            r_sat  <= '0;
            r_fill <= '0;
            r_mode <= '0;
            r_amt  <= '0;
         end else if (w_adv) begin
            r_sat  <= w_in_sat[STAGES-2:0];
            r_fill <= w_in_fill[STAGES-2:0];
            r_mode <= w_in_mode[STAGES-2:0];
            r_amt  <= w_in_amt[STAGES-2:0];
         end
      end

      for (genvar s = 1; s < STAGES; s++) begin : g_fwd
         assign w_in_vld[s]  = r_vld[s-1];
         assign w_in_data[s] = r_data[s-1];
         assign w_in_zext[s] = r_zext[s-1];
         assign w_in_sext[s] = r_sext[s-1];
         assign w_in_sat[s]  = r_sat[s-1];
         assign w_in_fill[s] = r_fill[s-1];
         assign w_in_mode[s] = r_mode[s-1];
         assign w_in_amt[s]  = r_amt[s-1];
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stg
      localparam int NL = lvl_count(LV, STAGES, s);
      localparam int LF = lvl_first(LV, STAGES, s);

      logic [NL:0][WIDTH-1:0] w_lvl;
      logic                   w_left;
      logic                   w_rot;

      assign w_left   = (w_in_mode[s] == MODE_SLL) || (w_in_mode[s] == MODE_ROL);
      assign w_rot    = (w_in_mode[s] == MODE_ROL) || (w_in_mode[s] == MODE_ROR);
      assign w_lvl[0] = w_in_data[s];

      for (genvar j = 0; j < NL; j++) begin : g_lvl
         shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (LF + j))
         ) u_lvl (
            .i_data (w_lvl[j]),
            .i_en   (w_in_amt[s][LF + j]),
            .i_left (w_left),
            .i_rot  (w_rot),
            .i_fill (w_in_fill[s]),
            .o_data (w_lvl[j+1])
         );
      end

      // Out-of-range linear shifts collapse to the fill pattern at the last stage.
      if (s == STAGES - 1) begin : g_sat
         assign w_nxt_data[s] = w_in_sat[s] ? {WIDTH{w_in_fill[s]}} : w_lvl[NL];
      end else begin : g_thru
         assign w_nxt_data[s] = w_lvl[NL];
      end
   end

   always_ff @(posedge CLK) begin
      if (!CtrlRstN) begin
         r_vld  <= '0;
         r_data <= '0;
         r_zext <= '0;
         r_sext <= '0;
      end else if (w_adv) begin
         r_vld  <= w_in_vld;
         r_data <= w_nxt_data;
         r_zext <= w_in_zext;
         r_sext <= w_in_sext;
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign out_data  = r_data[STAGES-1];
   assign out_zero  = (r_data[STAGES-1] == '0);
   assign out_zext  = r_zext[STAGES-1];
   assign out_sext  = r_sext[STAGES-1];

endmodule

// File: tb/tb_shift_ext_pipe.sv
// Bench for shift_ext_pipe: three instances (STAGES 2, 1, 4) share one stimulus
// stream; each is scored against its own queue-based reference model.
module tb_shift_ext_pipe;

   localparam int W  = 16;
   localparam int IW = 12;
   localparam int ND = 3;

   logic                CLK = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                out_ready;
   logic [W-1:0]        in_data;
   logic [IW-1:0]       in_imm;
   logic [2:0]          in_mode;

   logic [ND-1:0]        in_ready_a;
   logic [ND-1:0]        out_valid_a;
   logic [ND-1:0]        out_zero_a;
   logic [ND-1:0][W-1:0] out_data_a;
   logic [ND-1:0][W-1:0] out_zext_a;
   logic [ND-1:0][W-1:0] out_sext_a;

   int n_chk = 0;
   int n_err = 0;
   bit exact_lat = 1'b0;

   typedef struct {
      logic [W-1:0]  d;
      logic [IW-1:0] imm;
      logic [2:0]    m;
      int            acc;
      bit            ex;
   } txn_t;

   always #5 CLK = ~CLK;

   function automatic logic [W-1:0] gold(input logic [W-1:0] d, input logic [IW-1:0] imm,
                                         input logic [2:0] m);
      int a;
      int r;
      a = int'(imm);
      r = a % W;
      case (m)
         3'd0:    return (a >= W) ? 16'h0000 : 16'(d << a);
         3'd1:    return (a >= W) ? 16'h0000 : 16'(d >> a);
         3'd2:    return (a >= W) ? {W{d[W-1]}} : 16'($signed(d) >>> a);
         3'd3:    return 16'((d << r) | (d >> (W - r)));
         3'd4:    return 16'((d >> r) | (d << (W - r)));
         default: return d;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int STG = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

      shift_ext_pipe #(
         .WIDTH  (W),
         .IMM_W  (IW),
         .STAGES (STG)
      ) u_dut (
         .CLK       (CLK),
         .CtrlRstN  (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_a[g]),
         .in_data   (in_data),
         .in_imm    (in_imm),
         .in_mode   (in_mode),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready),
         .out_data  (out_data_a[g]),
         .out_zero  (out_zero_a[g]),
         .out_zext  (out_zext_a[g]),
         .out_sext  (out_sext_a[g])
      );

      txn_t         q[$];
      txn_t         t;
      logic [W-1:0] e;
      int           cyc  = 0;
      bit           rchk = 1'b0;

      // Everything is sampled mid-cycle; decisions apply to the coming rising edge.
      always @(negedge CLK) begin
         cyc++;
         if (rchk) begin
            chk($sformatf("s%0d_rst_valid", STG), 32'(out_valid_a[g]), 0);
            chk($sformatf("s%0d_rst_data", STG), 32'(out_data_a[g]), 0);
            chk($sformatf("s%0d_rst_zero", STG), 32'(out_zero_a[g]), 1);
            chk($sformatf("s%0d_rst_zext", STG), 32'(out_zext_a[g]), 0);
            chk($sformatf("s%0d_rst_sext", STG), 32'(out_sext_a[g]), 0);
            rchk = 1'b0;
         end
         if (out_valid_a[g] === 1'b1) begin
            if (q.size() == 0) begin
               chk($sformatf("s%0d_stale_valid", STG), 32'(out_valid_a[g]), 0);
            end else begin
               t = q[0];
               e = gold(t.d, t.imm, t.m);
               chk($sformatf("s%0d_data d=%h imm=%h m=%0d", STG, t.d, t.imm, t.m),
                   32'(out_data_a[g]), 32'(e));
               chk($sformatf("s%0d_zero", STG), 32'(out_zero_a[g]), 32'(e == 0));
               chk($sformatf("s%0d_zext", STG), 32'(out_zext_a[g]), 32'(t.imm));
               chk($sformatf("s%0d_sext", STG), 32'(out_sext_a[g]),
                   32'({{(W-IW){t.imm[IW-1]}}, t.imm}));
               if (t.ex) chk($sformatf("s%0d_latency", STG), 32'(cyc - t.acc), STG);
               if (out_ready) void'(q.pop_front());
            end
         end
         chk($sformatf("s%0d_in_ready", STG), 32'(in_ready_a[g]),
             32'(!out_valid_a[g] || out_ready));
         if (!rst_n) begin
            q.delete();
            rchk = 1'b1;
         end else if (in_valid && in_ready_a[g]) begin
            q.push_back('{in_data, in_imm, in_mode, cyc, exact_lat});
         end
      end
   end

   task automatic wait_acc();
      int n;
      n = 0;
      @(negedge CLK);
      while (!in_ready_a[0] && n < 50) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 50) chk("accept_timeout", 32'(in_ready_a[0]), 1);
   endtask

   task automatic put(input logic [W-1:0] d, input logic [IW-1:0] imm, input logic [2:0] m);
      @(posedge CLK);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      in_imm   = imm;
      in_mode  = m;
      wait_acc();
   endtask

   // Single transaction through the STAGES=2 instance with literal expectations.
   task automatic one(input string nm, input logic [W-1:0] d, input logic [IW-1:0] imm,
                      input logic [2:0] m, input logic [W-1:0] ed, input logic ez,
                      input logic [W-1:0] ezx, input logic [W-1:0] esx);
      put(d, imm, m);
      @(posedge CLK);
      #1 in_valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk({nm, "_valid"}, 32'(out_valid_a[0]), 1);
      chk({nm, "_data"}, 32'(out_data_a[0]), 32'(ed));
      chk({nm, "_zero"}, 32'(out_zero_a[0]), 32'(ez));
      chk({nm, "_zext"}, 32'(out_zext_a[0]), 32'(ezx));
      chk({nm, "_sext"}, 32'(out_sext_a[0]), 32'(esx));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_imm    = '0;
      in_mode   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1 rst_n = 1'b1;

      one("sll4",    16'hFFFF, 12'h004, 3'd0, 16'hFFF0, 1'b0, 16'h0004, 16'h0004);
      one("sll804",  16'hFFFF, 12'h804, 3'd0, 16'h0000, 1'b1, 16'h0804, 16'hF804);
      one("sra3",    16'h8000, 12'h003, 3'd2, 16'hF000, 1'b0, 16'h0003, 16'h0003);
      one("sra14",   16'h8000, 12'h014, 3'd2, 16'hFFFF, 1'b0, 16'h0014, 16'h0014);
      one("srl3",    16'h8000, 12'h003, 3'd1, 16'h1000, 1'b0, 16'h0003, 16'h0003);
      one("srl14",   16'h8000, 12'h014, 3'd1, 16'h0000, 1'b1, 16'h0014, 16'h0014);
      one("ror4",    16'h1234, 12'h004, 3'd4, 16'h4123, 1'b0, 16'h0004, 16'h0004);
      one("rol14",   16'h1234, 12'h014, 3'd3, 16'h2341, 1'b0, 16'h0014, 16'h0014);
      one("rol0",    16'h1234, 12'h000, 3'd3, 16'h1234, 1'b0, 16'h0000, 16'h0000);
      one("pass6",   16'h1234, 12'hFFF, 3'd6, 16'h1234, 1'b0, 16'h0FFF, 16'hFFFF);
      one("sll15",   16'h0003, 12'h00F, 3'd0, 16'h8000, 1'b0, 16'h000F, 16'h000F);
      one("sra15",   16'h8000, 12'h00F, 3'd2, 16'hFFFF, 1'b0, 16'h000F, 16'h000F);
      one("srl16",   16'hFFFF, 12'h010, 3'd1, 16'h0000, 1'b1, 16'h0010, 16'h0010);
      one("ror16",   16'h0F0F, 12'h010, 3'd4, 16'h0F0F, 1'b0, 16'h0010, 16'h0010);

      // Back-to-back streaming with exact latency tracking on every instance.
      exact_lat = 1'b1;
      for (int i = 0; i < 300; i++)
         put(16'($urandom), 12'($urandom_range(0, 4095)), 3'($urandom_range(0, 7)));
      @(posedge CLK);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge CLK);
      exact_lat = 1'b0;

      // Backpressure: stall the full STAGES=2 pipe for three cycles.
      put(16'h00F0, 12'h004, 3'd0);
      put(16'h00F0, 12'h004, 3'd1);
      put(16'h1234, 12'h008, 3'd4);
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
      in_data   = 16'h8001;
      in_imm    = 12'h001;
      in_mode   = 3'd2;
      repeat (3) begin
         @(negedge CLK);
         chk("bp_in_ready", 32'(in_ready_a[0]), 0);
         chk("bp_out_valid", 32'(out_valid_a[0]), 1);
         chk("bp_out_data", 32'(out_data_a[0]), 32'h000F);
      end
      @(posedge CLK);
      #1 out_ready = 1'b1;
      wait_acc();
      put(16'hABCD, 12'h000, 3'd3);
      put(16'h0001, 12'h00F, 3'd0);
      @(posedge CLK);
      #1 in_valid = 1'b0;
      repeat (8) @(posedge CLK);

      // Reset with two transactions in flight.
      put(16'h5555, 12'h001, 3'd0);
      put(16'hAAAA, 12'h001, 3'd1);
      @(posedge CLK);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(posedge CLK);
      #1 rst_n = 1'b1;
      @(negedge CLK);
      chk("rst_mid_valid", 32'(out_valid_a[0]), 0);
      chk("rst_mid_data", 32'(out_data_a[0]), 0);
      chk("rst_mid_zero", 32'(out_zero_a[0]), 1);
      chk("rst_mid_in_ready", 32'(in_ready_a[0]), 1);
      repeat (8) @(posedge CLK);
      one("post_rst", 16'h00FF, 12'h004, 3'd3, 16'h0FF0, 1'b0, 16'h0004, 16'h0004);
      repeat (6) @(posedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
